// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory access controller.
// Contents:
//   state_t    controller FSM states
//   req_t      requester identity used by the arbiter
//   NOP_INSTR  instruction returned on a faulting fetch
//   byte_sel   picks byte k of a little-endian 32-bit word
package imem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_LAST = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LOAD  = 1'b1
    } req_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_byte_assembler.sv
// Byte counter and little-endian word assembler.
// Ports:
//   clk, reset  clock, synchronous active-low reset
//   clr         restart the byte counter (new access accepted)
//   step        advance the byte counter by one
//   cap         shift rdata into the top of the word register
//   rdata       byte from RAM
//   cnt         current byte index 0..3
//   word_next   word as it will be after capturing rdata this cycle
// Bytes enter at the top and move down, so after four captures the
// first byte read sits in bits [7:0].
module imem_byte_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        step,
    input  logic        cap,
    input  logic [7:0]  rdata,
    output logic [1:0]  cnt,
    output logic [31:0] word_next
);

    logic [1:0]  cnt_r;
    logic [31:0] word_r;

    assign cnt       = cnt_r;
    assign word_next = {rdata, word_r[31:8]};

    // Byte counter and capture shift register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r  <= 2'd0;
            word_r <= 32'h0;
        end else begin
            if (clr) begin
                cnt_r <= 2'd0;
            end else if (step) begin
                cnt_r <= cnt_r + 2'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (cap) begin
                word_r <= word_next;
            end else begin
                word_r <= word_r;
            end
        end
    end

endmodule

// File: rtl/imem_access_ctrl.sv
// Sequences a single-port byte-wide RAM for a 32-bit fetch requester and a
// 32-bit loader requester. Each word becomes four byte accesses; read
// bytes are assembled little-endian. Ties are arbitrated round-robin.
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   fetch_req/addr/ready             fetch request handshake
//   fetch_valid/instr/fault          fetch response (valid is a 1-cycle pulse)
//   load_req/addr/data/ready         loader request handshake
//   load_done/fault                  loader response (done is a 1-cycle pulse)
//   mem_addr/we/wdata, mem_rdata     byte RAM, read data one cycle after addr
module imem_access_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int MEM_DEPTH = 256,
    localparam int IDX_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              fetch_fault,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_fault,
    output logic [IDX_W-1:0]  mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t             state_r;
    req_t               rr_last_r;
    logic [IDX_W-1:0]   base_r;
    logic [31:0]        data_r;
    logic               ready_r;
    logic [IDX_W-1:0]   mem_addr_r;
    logic               mem_we_r;
    logic [7:0]         mem_wdata_r;
    logic               fetch_valid_r;
    logic [31:0]        fetch_instr_r;
    logic               fetch_fault_r;
    logic               load_done_r;
    logic               load_fault_r;

    logic               accept_s;
    logic               tie_s;
    req_t               grant_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic               fault_s;
    logic               step_s;
    logic               cap_s;
    logic [1:0]         cnt_s;
    logic [1:0]         cnt_inc_s;
    logic [31:0]        word_next_s;
    logic [IDX_W-1:0]   addr_next_s;

    assign fetch_ready = ready_r;
    assign load_ready  = ready_r;
    assign fetch_valid = fetch_valid_r;
    assign fetch_instr = fetch_instr_r;
    assign fetch_fault = fetch_fault_r;
    assign load_done   = load_done_r;
    assign load_fault  = load_fault_r;
    assign mem_addr    = mem_addr_r;
    assign mem_we      = mem_we_r;
    assign mem_wdata   = mem_wdata_r;

    assign cnt_inc_s   = cnt_s + 2'd1;
    assign addr_next_s = base_r + IDX_W'(cnt_inc_s);

    // Arbitration and range check for the request seen in IDLE.
    always_comb begin
        accept_s = 1'b0;
        tie_s    = 1'b0;
        grant_s  = REQ_FETCH;
        if (state_r == ST_IDLE && fetch_req && load_req) begin
            accept_s = 1'b1;
            tie_s    = 1'b1;
            grant_s  = (rr_last_r == REQ_FETCH) ? REQ_LOAD : REQ_FETCH;
        end else if (state_r == ST_IDLE && load_req) begin
            accept_s = 1'b1;
            grant_s  = REQ_LOAD;
        end else if (state_r == ST_IDLE && fetch_req) begin
            accept_s = 1'b1;
            grant_s  = REQ_FETCH;
        end else begin
            accept_s = 1'b0;
            grant_s  = REQ_FETCH;
        end
        sel_addr_s = (grant_s == REQ_LOAD) ? load_addr : fetch_addr;
        // The last byte of the word must also be inside the RAM.
        fault_s    = (sel_addr_s >= ADDR_W'(MEM_DEPTH - 3));
    end

    // Assembler control: bytes 0..2 arrive during RD (one cycle late), byte 3 in RD_LAST.
    always_comb begin
        step_s = (state_r == ST_RD) || (state_r == ST_WR);
        if (state_r == ST_RD) begin
            cap_s = (cnt_s != 2'd0);
        end else if (state_r == ST_RD_LAST) begin
            cap_s = 1'b1;
        end else begin
            cap_s = 1'b0;
        end
    end

    imem_byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clr       (accept_s),
        .step      (step_s),
        .cap       (cap_s),
        .rdata     (mem_rdata),
        .cnt       (cnt_s),
        .word_next (word_next_s)
    );

    // Controller FSM with registered RAM and response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            rr_last_r     <= REQ_FETCH;
            base_r        <= '0;
            data_r        <= 32'h0;
            ready_r       <= 1'b1;
            mem_addr_r    <= '0;
            mem_we_r      <= 1'b0;
            mem_wdata_r   <= 8'h00;
            fetch_valid_r <= 1'b0;
            fetch_instr_r <= 32'h0;
            fetch_fault_r <= 1'b0;
            load_done_r   <= 1'b0;
            load_fault_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        base_r  <= sel_addr_s[IDX_W-1:0];
                        data_r  <= load_data;
                        ready_r <= 1'b0;
                        if (tie_s) begin
                            rr_last_r <= grant_s;
                        end else begin
                            rr_last_r <= rr_last_r;
                        end
                        if (fault_s) begin
                            state_r <= ST_RESP;
                            if (grant_s == REQ_LOAD) begin
                                load_done_r  <= 1'b1;
                                load_fault_r <= 1'b1;
                            end else begin
                                fetch_valid_r <= 1'b1;
                                fetch_fault_r <= 1'b1;
                                fetch_instr_r <= NOP_INSTR;
                            end
                        end else if (grant_s == REQ_LOAD) begin
                            state_r     <= ST_WR;
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= sel_addr_s[IDX_W-1:0];
                            mem_wdata_r <= load_data[7:0];
                        end else begin
                            state_r    <= ST_RD;
                            mem_addr_r <= sel_addr_s[IDX_W-1:0];
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (cnt_s == 2'd3) begin
                        state_r    <= ST_RD_LAST;
                        mem_addr_r <= '0;
                    end else begin
                        mem_addr_r <= addr_next_s;
                    end
                end
                ST_RD_LAST: begin
                    state_r       <= ST_RESP;
                    fetch_valid_r <= 1'b1;
                    fetch_fault_r <= 1'b0;
                    fetch_instr_r <= word_next_s;
                end
                ST_WR: begin
                    if (cnt_s == 2'd3) begin
                        state_r      <= ST_RESP;
                        mem_we_r     <= 1'b0;
                        mem_addr_r   <= '0;
                        mem_wdata_r  <= 8'h00;
                        load_done_r  <= 1'b1;
                        load_fault_r <= 1'b0;
                    end else begin
                        mem_addr_r  <= addr_next_s;
                        mem_wdata_r <= byte_sel(data_r, cnt_inc_s);
                    end
                end
                ST_RESP: begin
                    state_r       <= ST_IDLE;
                    ready_r       <= 1'b1;
                    fetch_valid_r <= 1'b0;
                    fetch_fault_r <= 1'b0;
                    load_done_r   <= 1'b0;
                    load_fault_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ready_r    <= 1'b1;
                    mem_we_r   <= 1'b0;
                    mem_addr_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed testbench for imem_access_ctrl with a behavioural byte RAM
// (synchronous write, synchronous read). RAM is preset to ram[i] = i.
module tb_imem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [63:0] fetch_addr;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;
    logic        load_req;
    logic [63:0] load_addr;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_done;
    logic        load_fault;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [0:255];
    logic        init_ram;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_access_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault),
        .load_req    (load_req),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .load_fault  (load_fault),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 256; i++) ram[i] <= i[7:0];
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 20; i++) begin
            if (fetch_ready) break;
            tick();
        end
        check("idle_timeout", {63'd0, fetch_ready}, 64'd1);
    endtask

    // Full write transaction with per-cycle checks; starts in IDLE.
    task automatic load_word(input logic [63:0] a, input logic [31:0] d);
        load_req = 1'b1; load_addr = a; load_data = d;
        tick();
        load_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("ld_we",    {63'd0, mem_we}, 64'd1);
            check("ld_addr",  {56'd0, mem_addr}, (a + 64'(k)) & 64'hFF);
            check("ld_wdata", {56'd0, mem_wdata}, 64'((d >> (8 * k)) & 32'hFF));
            check("ld_busy",  {62'd0, load_ready, load_done}, 64'd0);
            tick();
        end
        check("ld_done",  {62'd0, load_done, load_fault}, 64'd2);
        check("ld_we_off", {63'd0, mem_we}, 64'd0);
        tick();
        check("ld_after", {62'd0, load_done, load_ready}, 64'd1);
    endtask

    // Full read transaction with per-cycle checks; starts in IDLE.
    task automatic fetch_word(input logic [63:0] a, input logic [31:0] exp);
        fetch_req = 1'b1; fetch_addr = a;
        tick();
        fetch_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rd_addr", {56'd0, mem_addr}, (a + 64'(k)) & 64'hFF);
            check("rd_busy", {61'd0, mem_we, fetch_valid, fetch_ready}, 64'd0);
            tick();
        end
        check("rd_early", {63'd0, fetch_valid}, 64'd0);
        tick();
        check("rd_valid", {62'd0, fetch_valid, fetch_fault}, 64'd2);
        check("rd_instr", {32'd0, fetch_instr}, {32'd0, exp});
        tick();
        check("rd_hold",  {30'd0, fetch_valid, fetch_ready, fetch_instr}, {32'd1, exp});
    endtask

    initial begin
        bit prev_ready;
        bit last_we;
        int grants;
        int n_load;
        bit alt_ok;

        reset = 1'b0; init_ram = 1'b1;
        fetch_req = 1'b0; fetch_addr = 64'd0;
        load_req = 1'b0; load_addr = 64'd0; load_data = 32'd0;
        tick(); tick();
        init_ram = 1'b0;
        check("rst_ready", {62'd0, fetch_ready, load_ready}, 64'd3);
        check("rst_outs",  {59'd0, fetch_valid, fetch_fault, load_done, load_fault, mem_we}, 64'd0);
        check("rst_addr",  {24'd0, mem_addr, fetch_instr}, 64'd0);
        reset = 1'b1;
        tick();

        // Tie right after reset: loader first, fetch on next IDLE.
        fetch_req = 1'b1; fetch_addr = 64'd4;
        load_req = 1'b1;  load_addr = 64'd8; load_data = 32'hCAFE_F00D;
        tick();
        check("tie_load_first", {55'd0, mem_we, mem_addr}, {55'd0, 1'b1, 8'd8});
        check("tie_busy", {62'd0, fetch_ready, load_ready}, 64'd0);
        load_req = 1'b0;
        tick(); tick(); tick(); tick();
        check("tie_ld_done", {63'd0, load_done}, 64'd1);
        tick();
        check("tie_ready", {63'd0, fetch_ready}, 64'd1);
        tick();
        fetch_req = 1'b0;
        check("tie_fetch_next", {55'd0, mem_we, mem_addr}, {55'd0, 1'b0, 8'd4});
        check("tie_fetch_busy", {63'd0, fetch_ready}, 64'd0);
        tick(); tick(); tick(); tick(); tick();
        check("tie_fetch_val", {31'd0, fetch_valid, fetch_instr}, {31'd0, 1'b1, 32'h0706_0504});
        tick();

        // Basic load then fetch.
        load_word(64'd0, 32'h0020_8193);
        fetch_word(64'd0, 32'h0020_8193);

        // Out-of-range fetch.
        fetch_req = 1'b1; fetch_addr = 64'hFD;
        tick();
        fetch_req = 1'b0;
        check("flt_valid", {61'd0, fetch_valid, fetch_fault, mem_we}, 64'd6);
        check("flt_instr", {24'd0, mem_addr, fetch_instr}, 64'h0000_0013);
        tick();
        check("flt_after", {62'd0, fetch_valid, fetch_ready}, 64'd1);

        // Out-of-range load (high address bits set).
        load_req = 1'b1; load_addr = 64'h0000_0001_0000_0000; load_data = 32'hFFFF_FFFF;
        tick();
        load_req = 1'b0;
        check("lflt_done", {61'd0, load_done, load_fault, mem_we}, 64'd6);
        tick();

        // Highest legal word, and misaligned fetch across words.
        load_word(64'hFC, 32'hAABB_CCDD);
        fetch_word(64'hFC, 32'hAABB_CCDD);
        load_word(64'd0, 32'h1122_3344);
        load_word(64'd4, 32'h5566_7788);
        fetch_word(64'd2, 32'h7788_1122);

        // Reset while writing: bytes 0 and 1 land, 2 and 3 do not.
        load_req = 1'b1; load_addr = 64'h20; load_data = 32'hDEAD_BEEF;
        tick();
        load_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("rwr_we", {62'd0, mem_we, load_done}, 64'd0);
        reset = 1'b1;
        tick();
        check("rwr_ready", {61'd0, load_ready, load_done, mem_we}, 64'd4);
        fetch_word(64'h20, 32'h2322_BEEF);

        // Both requests held: grants must alternate.
        fetch_req = 1'b1; fetch_addr = 64'd0;
        load_req = 1'b1;  load_addr = 64'h40; load_data = 32'h0102_0304;
        prev_ready = fetch_ready;
        grants = 0; n_load = 0; alt_ok = 1'b1; last_we = 1'b0;
        for (int c = 0; c < 200 && grants < 10; c++) begin
            tick();
            if (prev_ready && !fetch_ready) begin
                if (grants > 0 && mem_we == last_we) alt_ok = 1'b0;
                last_we = mem_we;
                if (mem_we) n_load++;
                grants++;
            end
            prev_ready = fetch_ready;
        end
        fetch_req = 1'b0; load_req = 1'b0;
        check("rr_grants", 64'(grants), 64'd10);
        check("rr_alternate", {63'd0, alt_ok}, 64'd1);
        check("rr_loads", 64'(n_load), 64'd5);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
